// File: rtl/iob_ram_tdp_be_coll.sv
// Single-clock true-dual-port RAM with byte enables; same-address collisions merge per lane (A wins) and are counted.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); both ports accept an access every cycle, no backpressure.
module iob_ram_tdp_be_coll #(
  parameter          HEXFILE = "none",
  parameter int      ADDR_W  = 10,
  parameter int      DATA_W  = 32,
  parameter int      WR_MODE = 0,
  parameter int      OUT_REG = 0,
  parameter int      CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enA,
  input  logic [DATA_W/8-1:0] weA,
  input  logic [ADDR_W-1:0]   addrA,
  input  logic [DATA_W-1:0]   dinA,
  output logic [DATA_W-1:0]   doutA,
  output logic                dvalidA,
  input  logic                enB,
  input  logic [DATA_W/8-1:0] weB,
  input  logic [ADDR_W-1:0]   addrB,
  input  logic [DATA_W-1:0]   dinB,
  output logic [DATA_W-1:0]   doutB,
  output logic                dvalidB,
  output logic                coll,
  output logic [CNT_W-1:0]    coll_cnt
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accA, accB, sameAddr, collNow;
  logic [NB-1:0]     wrA, wrB, wrBEff;
  logic [DATA_W-1:0] oldA, oldB, mergedA, mergedB, rdA, rdB;

  // Accesses are masked during reset so memory contents survive it untouched.
  always_comb begin
    accA     = enA & rst_n;
    accB     = enB & rst_n;
    wrA      = accA ? weA : '0;
    wrB      = accB ? weB : '0;
    sameAddr = accA && accB && (addrA == addrB);
    collNow  = sameAddr && ((|wrA) || (|wrB));
    wrBEff   = sameAddr ? (wrB & ~wrA) : wrB;
  end

  always_comb begin
    oldA    = mem[addrA];
    oldB    = mem[addrB];
    mergedA = oldA;
    mergedB = oldB;
    for (int i = 0; i < NB; i++) begin
      if (wrA[i])
        mergedA[8*i +: 8] = dinA[8*i +: 8];
      else if (sameAddr && wrBEff[i])
        mergedA[8*i +: 8] = dinB[8*i +: 8];
      if (wrBEff[i])
        mergedB[8*i +: 8] = dinB[8*i +: 8];
      else if (sameAddr && wrA[i])
        mergedB[8*i +: 8] = dinA[8*i +: 8];
    end
    rdA = (WR_MODE != 0) ? mergedA : oldA;
    rdB = (WR_MODE != 0) ? mergedB : oldB;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wrA[i])
        mem[addrA][8*i +: 8] <= dinA[8*i +: 8];
      if (wrBEff[i])
        mem[addrB][8*i +: 8] <= dinB[8*i +: 8];
    end
  end

  logic              vldA1, vldB1, coll1;
  logic [DATA_W-1:0] datA1, datB1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldA1 <= 1'b0;
      vldB1 <= 1'b0;
      coll1 <= 1'b0;
      datA1 <= '0;
      datB1 <= '0;
    end else begin
      vldA1 <= accA;
      vldB1 <= accB;
      coll1 <= collNow;
      if (accA) datA1 <= rdA;
      if (accB) datB1 <= rdB;
    end
  end

  logic collEvt;

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic              vldA2, vldB2, coll2;
      logic [DATA_W-1:0] datA2, datB2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vldA2 <= 1'b0;
          vldB2 <= 1'b0;
          coll2 <= 1'b0;
          datA2 <= '0;
          datB2 <= '0;
        end else begin
          vldA2 <= vldA1;
          vldB2 <= vldB1;
          coll2 <= coll1;
          if (vldA1) datA2 <= datA1;
          if (vldB1) datB2 <= datB1;
        end
      end

      assign doutA   = datA2;
      assign doutB   = datB2;
      assign dvalidA = vldA2;
      assign dvalidB = vldB2;
      assign coll    = coll2;
      assign collEvt = coll1;
    end else begin : gNoOutReg
      assign doutA   = datA1;
      assign doutB   = datB1;
      assign dvalidA = vldA1;
      assign dvalidB = vldB1;
      assign coll    = coll1;
      assign collEvt = collNow;
    end
  endgenerate

  // Counter moves on the same edge that raises coll, so both are visible together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      coll_cnt <= '0;
    else if (collEvt && (coll_cnt != {CNT_W{1'b1}}))
      coll_cnt <= coll_cnt + CNT_W'(1);
  end

endmodule
